meter_pll_reconfig_ctrl: RTL and testbench

Sequencer for the meter PLL's output-divider reconfiguration. It accepts new clkout0 divider and duty settings over a valid/ready handshake and drives the PLL's dynamic inputs. It pulses the PLL reset, waits for a stable lock with timeout and bounded retry, then reports done or error. It sits between the spectrum-analyzer control logic and the meter_pll instance.

---
 rtl/meter_pll_ctrl_pkg.sv | 24 ++
 rtl/meter_pll_lock_sync.sv | 37 +++
 rtl/meter_pll_reconfig_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_meter_pll_reconfig_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/meter_pll_ctrl_pkg.sv
// Shared types and constants for the meter PLL reconfiguration controller.
// Holds the sequencer state encoding and the request validity rule.
package meter_pll_ctrl_pkg;

    localparam int ODIV_W        = 10;
    localparam int DUTY_W        = 10;
    localparam int LOSS_DEBOUNCE = 4;
    localparam int SYNC_STAGES   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_ASSERT,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_CHECK_FAIL
    } state_t;

    // A zero divider or zero duty would stall the PLL output, so such requests are refused.
    function automatic logic cfg_is_valid(input logic [ODIV_W-1:0] odiv,
                                          input logic [DUTY_W-1:0] duty);
        return (odiv != '0) && (duty != '0);
    endfunction

endpackage

// File: rtl/meter_pll_lock_sync.sv
// Brings the asynchronous PLL lock into the clk domain and flags a sustained
// loss of lock (lock_s low for LOSS_DEBOUNCE consecutive cycles).
module meter_pll_lock_sync
    import meter_pll_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic lock_async,
    output logic lock_s,
    output logic lock_lost
);

    localparam int LOW_W = $clog2(LOSS_DEBOUNCE + 1);
    localparam logic [LOW_W-1:0] LOW_MAX = LOW_W'(LOSS_DEBOUNCE);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [LOW_W-1:0]       low_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg    <= '0;
            low_cnt_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], lock_async};
            // Counts consecutive low samples of the synchronized lock, saturating.
            if (sync_reg[SYNC_STAGES-1]) begin
                low_cnt_reg <= '0;
            end else if (low_cnt_reg != LOW_MAX) begin
                low_cnt_reg <= low_cnt_reg + 1'b1;
            end
        end
    end

    assign lock_s    = sync_reg[SYNC_STAGES-1];
    assign lock_lost = (low_cnt_reg == LOW_MAX);

endmodule

// File: rtl/meter_pll_reconfig_ctrl.sv
// Sequencer that loads new clkout0 divider/duty settings into the meter PLL,
// pulses its reset and waits for a stable lock with timeout and bounded retry.
// Define METER_PLL_LOCK_MON_EN to add automatic relock on sustained lock loss.
module meter_pll_reconfig_ctrl
    import meter_pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRY     = 3,
    parameter int DEF_ODIV      = 100,
    parameter int DEF_DUTY      = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ODIV_W-1:0] cfg_odiv,
    input  logic [DUTY_W-1:0] cfg_duty,
    input  logic              pll_lock,
    output logic              pll_rst,
    output logic [ODIV_W-1:0] dyn_odiv0,
    output logic [DUTY_W-1:0] dyn_duty0,
    output logic              busy,
    output logic              locked,
    output logic              done,
    output logic              err,
    output logic [2:0]        retry_cnt
`ifdef METER_PLL_LOCK_MON_EN
    ,
    output logic [7:0]        lock_loss_cnt
`endif
);

    localparam int RC_W = $clog2(RST_CYCLES);
    localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int SC_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    localparam logic [RC_W-1:0]   RST_LAST    = RC_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_MAX      = TO_W'(LOCK_TIMEOUT);
    localparam logic [SC_W-1:0]   STAB_LAST   = SC_W'(STABLE_CYCLES - 1);
    localparam logic [2:0]        RETRY_MAX   = 3'(MAX_RETRY);
    localparam logic [ODIV_W-1:0] ODIV_RESET  = ODIV_W'(DEF_ODIV);
    localparam logic [DUTY_W-1:0] DUTY_RESET  = DUTY_W'(DEF_DUTY);

    state_t             state_reg;
    logic               pll_rst_reg;
    logic [ODIV_W-1:0]  odiv_reg;
    logic [DUTY_W-1:0]  duty_reg;
    logic               cfg_ready_reg;
    logic               busy_reg;
    logic               locked_reg;
    logic               done_reg;
    logic               err_reg;
    logic [2:0]         retry_reg;
    logic [RC_W-1:0]    rst_cnt_reg;
    logic [TO_W-1:0]    to_cnt_reg;
    logic [SC_W-1:0]    stab_cnt_reg;
`ifdef METER_PLL_LOCK_MON_EN
    logic [7:0]         loss_cnt_reg;
`endif

    logic lock_s;
    logic lock_lost;
    logic timeout;

    meter_pll_lock_sync u_lock_sync (
        .clk        (clk),
        .rst        (rst),
        .lock_async (pll_lock),
        .lock_s     (lock_s),
        .lock_lost  (lock_lost)
    );

    // The timeout counter spans the whole search (WAIT_LOCK and STABLE) of one attempt.
    assign timeout = (to_cnt_reg == TO_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RST_ASSERT;
            pll_rst_reg   <= 1'b1;
            odiv_reg      <= ODIV_RESET;
            duty_reg      <= DUTY_RESET;
            cfg_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            locked_reg    <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            retry_reg     <= '0;
            rst_cnt_reg   <= '0;
            to_cnt_reg    <= '0;
            stab_cnt_reg  <= '0;
`ifdef METER_PLL_LOCK_MON_EN
            loss_cnt_reg  <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cfg_valid && cfg_ready_reg) begin
                        if (cfg_is_valid(cfg_odiv, cfg_duty)) begin
                            odiv_reg      <= cfg_odiv;
                            duty_reg      <= cfg_duty;
                            locked_reg    <= 1'b0;
                            retry_reg     <= '0;
                            pll_rst_reg   <= 1'b1;
                            rst_cnt_reg   <= '0;
                            cfg_ready_reg <= 1'b0;
                            busy_reg      <= 1'b1;
                            state_reg     <= ST_RST_ASSERT;
                        end else begin
                            err_reg <= 1'b1;
                        end
`ifdef METER_PLL_LOCK_MON_EN
                    end else if (locked_reg && lock_lost) begin
                        // Sustained lock loss: rerun the sequence with the current settings.
                        locked_reg    <= 1'b0;
                        retry_reg     <= '0;
                        pll_rst_reg   <= 1'b1;
                        rst_cnt_reg   <= '0;
                        cfg_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_RST_ASSERT;
                        if (loss_cnt_reg != 8'hFF) begin
                            loss_cnt_reg <= loss_cnt_reg + 1'b1;
                        end
                    end
`else
                    end else if (!lock_s || lock_lost) begin
                        locked_reg <= 1'b0;
                    end
`endif
                end

                ST_RST_ASSERT: begin
                    if (rst_cnt_reg == RST_LAST) begin
                        pll_rst_reg <= 1'b0;
                        to_cnt_reg  <= '0;
                        state_reg   <= ST_WAIT_LOCK;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    if (timeout) begin
                        state_reg <= ST_CHECK_FAIL;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                        if (lock_s) begin
                            stab_cnt_reg <= '0;
                            state_reg    <= ST_STABLE;
                        end
                    end
                end

                ST_STABLE: begin
                    // Timeout is tested first so it wins over a coincident stable completion.
                    if (timeout) begin
                        state_reg <= ST_CHECK_FAIL;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                        if (!lock_s) begin
                            state_reg <= ST_WAIT_LOCK;
                        end else if (stab_cnt_reg == STAB_LAST) begin
                            done_reg      <= 1'b1;
                            locked_reg    <= 1'b1;
                            cfg_ready_reg <= 1'b1;
                            busy_reg      <= 1'b0;
                            state_reg     <= ST_IDLE;
                        end else begin
                            stab_cnt_reg <= stab_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_CHECK_FAIL: begin
                    if (retry_reg < RETRY_MAX) begin
                        retry_reg   <= retry_reg + 1'b1;
                        pll_rst_reg <= 1'b1;
                        rst_cnt_reg <= '0;
                        state_reg   <= ST_RST_ASSERT;
                    end else begin
                        err_reg       <= 1'b1;
                        locked_reg    <= 1'b0;
                        pll_rst_reg   <= 1'b0;
                        cfg_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end

                default: begin
                    pll_rst_reg   <= 1'b0;
                    cfg_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = cfg_ready_reg;
    assign pll_rst   = pll_rst_reg;
    assign dyn_odiv0 = odiv_reg;
    assign dyn_duty0 = duty_reg;
    assign busy      = busy_reg;
    assign locked    = locked_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign retry_cnt = retry_reg;
`ifdef METER_PLL_LOCK_MON_EN
    assign lock_loss_cnt = loss_cnt_reg;
`endif

endmodule

// File: tb/tb_meter_pll_reconfig_ctrl.sv
// Directed/randomized bench for meter_pll_reconfig_ctrl with a behavioural PLL
// lock model; expected timing is derived from the controller's sequencing rules.
module tb_meter_pll_reconfig_ctrl;

    localparam int RST_CYCLES    = 16;
    localparam int LOCK_TIMEOUT  = 1000;
    localparam int STABLE_CYCLES = 256;
    localparam int MAX_RETRY     = 3;
    localparam int DEF_ODIV      = 100;
    localparam int DEF_DUTY      = 100;
    // Two synchronizer flops, one cycle to enter STABLE, then STABLE_CYCLES of counting.
    localparam int DONE_LAT      = STABLE_CYCLES + 3;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [9:0] cfg_odiv;
    logic [9:0] cfg_duty;
    logic       pll_lock;
    logic       pll_rst;
    logic [9:0] dyn_odiv0;
    logic [9:0] dyn_duty0;
    logic       busy;
    logic       locked;
    logic       done;
    logic       err;
    logic [2:0] retry_cnt;
`ifdef METER_PLL_LOCK_MON_EN
    logic [7:0] lock_loss_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_odiv;
    logic [9:0] exp_duty;

    meter_pll_reconfig_ctrl #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRY     (MAX_RETRY),
        .DEF_ODIV      (DEF_ODIV),
        .DEF_DUTY      (DEF_DUTY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_odiv  (cfg_odiv),
        .cfg_duty  (cfg_duty),
        .pll_lock  (pll_lock),
        .pll_rst   (pll_rst),
        .dyn_odiv0 (dyn_odiv0),
        .dyn_duty0 (dyn_duty0),
        .busy      (busy),
        .locked    (locked),
        .done      (done),
        .err       (err),
        .retry_cnt (retry_cnt)
`ifdef METER_PLL_LOCK_MON_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Counts negedge samples with pll_rst high, starting at the current sample.
    task automatic count_rst_high(input string tag);
        int n = 0;
        while (pll_rst === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_rst_len"}, n, RST_CYCLES);
        $display("[%0t] %s: pll_rst high for %0d cycles", $time, tag, n);
    endtask

    // PLL model: lock rises `delay` cycles after reset release; expects a done pulse.
    task automatic lock_and_done(input int delay, input string tag);
        int k = 0;
        repeat (delay) @(negedge clk);
        pll_lock = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (done !== 1'b1 && k < 3000);
        check({tag, "_done_lat"}, k, DONE_LAT);
        check({tag, "_locked"}, locked, 1);
        check({tag, "_ready"}, cfg_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_retry"}, retry_cnt, 0);
        check({tag, "_odiv"}, dyn_odiv0, exp_odiv);
        check({tag, "_duty"}, dyn_duty0, exp_duty);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        $display("[%0t] %s: done %0d cycles after lock, odiv=%0d duty=%0d", $time, tag, k, dyn_odiv0, dyn_duty0);
    endtask

    task automatic send_cfg(input logic [9:0] odiv, input logic [9:0] duty, input string tag);
        int k = 0;
        logic good;
        good = (odiv != 10'd0) && (duty != 10'd0);
        while (cfg_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready_wait"}, cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_odiv  = odiv;
        cfg_duty  = duty;
        if (good) pll_lock = 1'b0;
        @(negedge clk);
        cfg_valid = 1'b0;
        if (good) begin
            exp_odiv = odiv;
            exp_duty = duty;
            check({tag, "_odiv"}, dyn_odiv0, exp_odiv);
            check({tag, "_duty"}, dyn_duty0, exp_duty);
            check({tag, "_pll_rst"}, pll_rst, 1);
            check({tag, "_locked_clr"}, locked, 0);
            check({tag, "_retry_clr"}, retry_cnt, 0);
            check({tag, "_busy"}, busy, 1);
        end else begin
            check({tag, "_err"}, err, 1);
            check({tag, "_no_rst"}, pll_rst, 0);
            check({tag, "_odiv_kept"}, dyn_odiv0, exp_odiv);
            check({tag, "_duty_kept"}, dyn_duty0, exp_duty);
            check({tag, "_ready"}, cfg_ready, 1);
            @(negedge clk);
            check({tag, "_err_pulse"}, err, 0);
        end
        $display("[%0t] %s: request odiv=%0d duty=%0d accepted=%0d", $time, tag, odiv, duty, good);
    endtask

    initial begin
        int pulses, errs, gap, cyc, g;
        logic prev_rst, saw_done;

        rst = 1'b1; cfg_valid = 1'b0; cfg_odiv = '0; cfg_duty = '0; pll_lock = 1'b0;
        exp_odiv = 10'(DEF_ODIV);
        exp_duty = 10'(DEF_DUTY);
        repeat (3) @(negedge clk);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_odiv", dyn_odiv0, DEF_ODIV);
        check("rst_duty", dyn_duty0, DEF_DUTY);
        check("rst_ready", cfg_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_locked", locked, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_retry", retry_cnt, 0);
        $display("[%0t] reset state sampled", $time);

        // Power-up sequence with default settings.
        rst = 1'b0;
        count_rst_high("pwrup");
        lock_and_done(int'($urandom_range(20, 400)), "pwrup");

        // Directed 200/200 request, then randomized requests.
        send_cfg(10'd200, 10'd200, "cfg200");
        count_rst_high("cfg200");
        lock_and_done(int'($urandom_range(20, 400)), "cfg200");
        for (int i = 0; i < 2; i++) begin
            send_cfg(10'($urandom_range(1, 1023)), 10'($urandom_range(1, 1023)), "cfg_rand");
            count_rst_high("cfg_rand");
            lock_and_done(int'($urandom_range(0, 400)), "cfg_rand");
        end

        // Invalid requests are refused without touching the PLL.
        send_cfg(10'd0, 10'($urandom_range(1, 1023)), "rej_odiv");
        send_cfg(10'($urandom_range(1, 1023)), 10'd0, "rej_duty");
        check("rej_locked_kept", locked, 1);

        // Lock glitch during stable counting restarts the stable window.
        send_cfg(10'($urandom_range(1, 1023)), 10'($urandom_range(1, 1023)), "glitch");
        count_rst_high("glitch");
        repeat (int'($urandom_range(10, 200))) @(negedge clk);
        pll_lock = 1'b1;
        g = int'($urandom_range(50, 150));
        saw_done = 1'b0;
        repeat (g + 3) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        pll_lock = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("glitch_no_early_done", saw_done, 0);
        $display("[%0t] glitch: 3-cycle drop at stable count ~%0d", $time, g);
        lock_and_done(0, "glitch");

        // Reset in the middle of WAIT_LOCK restores defaults and reruns power-up.
        send_cfg(10'($urandom_range(1, 1023)), 10'($urandom_range(1, 1023)), "midrst");
        count_rst_high("midrst");
        repeat (50) @(negedge clk);
        check("midrst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        exp_odiv = 10'(DEF_ODIV);
        exp_duty = 10'(DEF_DUTY);
        check("midrst_odiv", dyn_odiv0, exp_odiv);
        check("midrst_duty", dyn_duty0, exp_duty);
        check("midrst_pll_rst", pll_rst, 1);
        check("midrst_ready", cfg_ready, 0);
        rst = 1'b0;
        count_rst_high("midrst_pwrup");
        lock_and_done(int'($urandom_range(20, 400)), "midrst_pwrup");

        // Lock never arrives: MAX_RETRY+1 attempts then one error pulse.
        send_cfg(10'($urandom_range(1, 1023)), 10'($urandom_range(1, 1023)), "tmo");
        pulses = 1; errs = 0; gap = 0; cyc = 0; prev_rst = 1'b1;
        while (cfg_ready !== 1'b1 && cyc < 10000) begin
            @(negedge clk);
            cyc++;
            if (err === 1'b1) errs++;
            if (pll_rst === 1'b1 && prev_rst === 1'b0) begin
                pulses++;
                check_range("tmo_search_len", gap, LOCK_TIMEOUT, LOCK_TIMEOUT + 3);
            end
            if (pll_rst === 1'b0) gap++;
            else gap = 0;
            prev_rst = pll_rst;
        end
        check("tmo_pulses", pulses, MAX_RETRY + 1);
        check("tmo_err_count", errs, 1);
        check("tmo_retry", retry_cnt, MAX_RETRY);
        check("tmo_locked", locked, 0);
        check("tmo_pll_rst", pll_rst, 0);
        check("tmo_odiv_kept", dyn_odiv0, exp_odiv);
        @(negedge clk);
        check("tmo_err_pulse", err, 0);
        $display("[%0t] timeout: %0d reset pulses, %0d err pulses, retry_cnt=%0d", $time, pulses, errs, retry_cnt);

        // Recovery after a failed sequence.
        send_cfg(10'($urandom_range(1, 1023)), 10'($urandom_range(1, 1023)), "recover");
        count_rst_high("recover");
        lock_and_done(int'($urandom_range(20, 400)), "recover");

`ifdef METER_PLL_LOCK_MON_EN
        // Short drop is filtered; a long drop triggers a relock.
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        pll_lock = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (pll_rst === 1'b1) saw_done = 1'b1;
        end
        check("mon_short_no_relock", saw_done, 0);
        check("mon_short_locked", locked, 1);
        check("mon_short_cnt", lock_loss_cnt, 0);
        $display("[%0t] monitor: 2-cycle drop, loss_cnt=%0d", $time, lock_loss_cnt);
        pll_lock = 1'b0;
        cyc = 0;
        while (pll_rst !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("mon_long_relock", pll_rst, 1);
        check("mon_long_cnt", lock_loss_cnt, 1);
        check("mon_long_locked", locked, 0);
        check("mon_long_odiv", dyn_odiv0, exp_odiv);
        $display("[%0t] monitor: long drop, relock after %0d cycles, loss_cnt=%0d", $time, cyc, lock_loss_cnt);
        count_rst_high("relock");
        lock_and_done(int'($urandom_range(20, 400)), "relock");
`else
        // Without the monitor a lock loss only clears locked.
        pll_lock = 1'b0;
        repeat (6) @(negedge clk);
        check("loss_locked_clr", locked, 0);
        check("loss_no_relock", pll_rst, 0);
        check("loss_ready", cfg_ready, 1);
        $display("[%0t] lock loss in idle: locked=%0d pll_rst=%0d", $time, locked, pll_rst);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
